// File: rtl/pwm_pkg.sv
// Shared defaults and RPM-to-duty conversion for the multi-channel motor PWM.
package pwm_pkg;

    localparam int DEFAULT_PERIOD    = 100;
    localparam int DEFAULT_RPM_MIN   = 500;
    localparam int DEFAULT_RPM_SHIFT = 6;
    localparam int DEFAULT_DUTY_MAX  = 90;
    localparam int DEFAULT_DUTY_W    = $clog2(DEFAULT_PERIOD + 1);

    // Commands at or below rpm_min give zero duty, so the subtraction never wraps.
    function automatic logic [31:0] rpm_to_duty(
        input logic [31:0] rpm_val,
        input logic [31:0] rpm_min,
        input int unsigned shift,
        input logic [31:0] duty_max
    );
        logic [31:0] scaled;
        if (rpm_val <= rpm_min) begin
            return 32'd0;
        end
        scaled = (rpm_val - rpm_min) >> shift;
        return (scaled > duty_max) ? duty_max : scaled;
    endfunction

endpackage

// File: rtl/pwm_multi_channel.sv
// One motor lane: double-buffered duty (pending/active), optional slew, output compare.
// Slew limiting is compiled in with `define PWM_SLEW_EN.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int RPM_W     = 16,
    parameter int PERIOD    = DEFAULT_PERIOD,
    parameter int RPM_MIN   = DEFAULT_RPM_MIN,
    parameter int RPM_SHIFT = DEFAULT_RPM_SHIFT,
    parameter int DUTY_MAX  = DEFAULT_DUTY_MAX,
    parameter int SLEW_STEP = 5,
    parameter int PHASE_W   = $clog2(PERIOD)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               load,
    input  logic               boundary,
    input  logic [RPM_W-1:0]   rpm_cmd,
    input  logic [PHASE_W-1:0] phase,
    output logic               pwm_out
);

    localparam int DUTY_W = $clog2(PERIOD + 1);

    logic [DUTY_W-1:0] duty_conv;
    logic [DUTY_W-1:0] pending_reg;
    logic [DUTY_W-1:0] active_reg;
    logic [DUTY_W-1:0] active_next;
    logic              pwm_reg;

    assign duty_conv = DUTY_W'(rpm_to_duty(32'(rpm_cmd), 32'(RPM_MIN), RPM_SHIFT, 32'(DUTY_MAX)));

`ifdef PWM_SLEW_EN
    // Step toward pending by at most SLEW_STEP; compare at 32 bits so the sum cannot wrap.
    always_comb begin
        active_next = pending_reg;
        if (32'(pending_reg) > 32'(active_reg) + 32'(SLEW_STEP)) begin
            active_next = active_reg + DUTY_W'(SLEW_STEP);
        end else if (32'(active_reg) > 32'(pending_reg) + 32'(SLEW_STEP)) begin
            active_next = active_reg - DUTY_W'(SLEW_STEP);
        end
    end
`else
    logic [31:0] unused_slew_step;
    assign unused_slew_step = 32'(SLEW_STEP);

    always_comb begin
        active_next = pending_reg;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_reg <= '0;
            active_reg  <= '0;
            pwm_reg     <= 1'b0;
        end else begin
            if (load) begin
                pending_reg <= duty_conv;
            end
            // Disarm wins over a boundary so re-arming always starts from zero duty.
            if (!enable) begin
                active_reg <= '0;
            end else if (boundary) begin
                active_reg <= active_next;
            end
            pwm_reg <= enable && (DUTY_W'(phase) < active_reg);
        end
    end

    assign pwm_out = pwm_reg;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel motor PWM: shared prescaler/phase counter, one pwm_channel per motor.
// Optional feature macro: PWM_SLEW_EN (per-period duty slew limiting in each channel).
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int RPM_W     = 16,
    parameter int PERIOD    = DEFAULT_PERIOD,
    parameter int PRESCALE  = 25,
    parameter int RPM_MIN   = DEFAULT_RPM_MIN,
    parameter int RPM_SHIFT = DEFAULT_RPM_SHIFT,
    parameter int DUTY_MAX  = DEFAULT_DUTY_MAX,
    parameter int SLEW_STEP = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    rpm_load,
    input  logic [NUM_CH*RPM_W-1:0] rpm,
    output logic [NUM_CH-1:0]       mot_pwm,
    output logic                    period_start
);

    localparam int PRE_W   = $clog2(PRESCALE + 1);
    localparam int PHASE_W = $clog2(PERIOD);

    logic [PRE_W-1:0]   pre_reg;
    logic [PHASE_W-1:0] phase_reg;
    logic               period_start_reg;
    logic               tick;
    logic               boundary;

    assign tick     = (pre_reg == PRE_W'(PRESCALE - 1));
    assign boundary = tick && (phase_reg == PHASE_W'(PERIOD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_reg          <= '0;
            phase_reg        <= '0;
            period_start_reg <= 1'b0;
        end else begin
            pre_reg <= tick ? '0 : pre_reg + 1'b1;
            if (tick) begin
                phase_reg <= boundary ? '0 : phase_reg + 1'b1;
            end
            period_start_reg <= boundary;
        end
    end

    assign period_start = period_start_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            pwm_channel #(
                .RPM_W    (RPM_W),
                .PERIOD   (PERIOD),
                .RPM_MIN  (RPM_MIN),
                .RPM_SHIFT(RPM_SHIFT),
                .DUTY_MAX (DUTY_MAX),
                .SLEW_STEP(SLEW_STEP),
                .PHASE_W  (PHASE_W)
            ) u_ch (
                .clk     (clk),
                .reset   (reset),
                .enable  (enable),
                .load    (rpm_load),
                .boundary(boundary),
                .rpm_cmd (rpm[gi*RPM_W +: RPM_W]),
                .phase   (phase_reg),
                .pwm_out (mot_pwm[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: duty vectors, boundary-cycle load, disarm/re-arm, mid-period reset.
module tb_pwm_multi;

    localparam int NUM_CH = 4;
    localparam int PLEN   = 2500;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic                 rpm_load;
    logic [NUM_CH*16-1:0] rpm;
    logic [NUM_CH-1:0]    mot_pwm;
    logic                 period_start;

    int checks_total  = 0;
    int checks_passed = 0;
    int act_m [NUM_CH];
    int pend_m[NUM_CH];

    typedef struct {
        logic [NUM_CH-1:0][15:0] rpm;
        int                      duty[NUM_CH];
    } vec_t;

    vec_t vecs[4];

    pwm_multi dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .rpm_load    (rpm_load),
        .rpm         (rpm),
        .mot_pwm     (mot_pwm),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks_total++;
        if (got == exp) checks_passed++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Boundary duty update: slew-limited when the feature is compiled in.
    function automatic int approach(input int a, input int p);
`ifdef PWM_SLEW_EN
        if (p > a + 5) return a + 5;
        if (p < a - 5) return a - 5;
        return p;
`else
        return p;
`endif
    endfunction

    function automatic int exp_mask();
        int m = 0;
        for (int i = 0; i < NUM_CH; i++) if (act_m[i] > 0) m |= (1 << i);
        return m;
    endfunction

    task automatic set_vec(input int idx, input int r0, input int r1, input int r2, input int r3,
                           input int d0, input int d1, input int d2, input int d3);
        vecs[idx].rpm[0] = 16'(r0); vecs[idx].rpm[1] = 16'(r1);
        vecs[idx].rpm[2] = 16'(r2); vecs[idx].rpm[3] = 16'(r3);
        vecs[idx].duty[0] = d0; vecs[idx].duty[1] = d1;
        vecs[idx].duty[2] = d2; vecs[idx].duty[3] = d3;
    endtask

    task automatic wait_ps(input string name);
        int guard = 0;
        while (!period_start && guard < 3000) begin
            step();
            guard++;
        end
        if (!period_start) check({name, " period_start timeout"}, 0, 1);
    endtask

    task automatic pulse_load(input logic [NUM_CH*16-1:0] value);
        rpm      = value;
        rpm_load = 1'b1;
        step();
        rpm_load = 1'b0;
    endtask

    // Measure one whole period starting at the period_start cycle.
    task automatic measure(input string name);
        int hi[NUM_CH];
        int early = 0;
        wait_ps(name);
        for (int i = 0; i < NUM_CH; i++) begin
            act_m[i] = approach(act_m[i], pend_m[i]);
            hi[i] = 0;
        end
        for (int c = 0; c < PLEN; c++) begin
            for (int i = 0; i < NUM_CH; i++) if (mot_pwm[i]) hi[i]++;
            if (c == 0) check({name, " low at period_start"}, int'(mot_pwm), 0);
            if (c == 1) check({name, " aligned rise"}, int'(mot_pwm), exp_mask());
            if (c > 0 && period_start) early++;
            step();
        end
        check({name, " period length"}, int'(period_start) + early * 2, 1);
        for (int i = 0; i < NUM_CH; i++)
            check($sformatf("%s ch%0d high cycles", name, i), hi[i], act_m[i] * 25);
        $display("%s: high=%0d,%0d,%0d,%0d", name, hi[0], hi[1], hi[2], hi[3]);
    endtask

    initial begin
        int n;
        logic [NUM_CH*16-1:0] bus;

        set_vec(0,  500,   500,  500,  500,   0,  0,  0,  0);
        set_vec(1, 3700, 65535,  501,  564,  50, 90,  0,  1);
        set_vec(2,  563,  6260, 1140,    0,   0, 90, 10,  0);
        set_vec(3, 6324,  5000, 2420, 3700,  90, 70, 30, 50);
        for (int i = 0; i < NUM_CH; i++) begin
            act_m[i]  = 0;
            pend_m[i] = 0;
        end

        reset    = 1'b1;
        enable   = 1'b1;
        rpm_load = 1'b0;
        rpm      = '0;
        repeat (3) step();
        check("reset mot_pwm", int'(mot_pwm), 0);
        check("reset period_start", int'(period_start), 0);
        reset = 1'b0;
        step();

        for (int v = 0; v < 4; v++) begin
            step();
            pulse_load(vecs[v].rpm);
            for (int i = 0; i < NUM_CH; i++) pend_m[i] = vecs[v].duty[i];
            for (int r = 0; r < ((v == 0) ? 3 : 1); r++) measure($sformatf("vec%0d", v));
        end

        // rpm_load in the boundary cycle: old pending holds one more period.
        repeat (PLEN - 1) step();
        bus = {16'd6260, 16'd500, 16'd3700, 16'd1140};
        pulse_load(bus);
        check("boundary-load period_start", int'(period_start), 1);
        measure("boundary old");
        pend_m[0] = 10; pend_m[1] = 50; pend_m[2] = 0; pend_m[3] = 90;
        measure("boundary new");

        // Disarm mid-high, reload while disarmed, re-arm.
        repeat (5) step();
        check("armed mask", int'(mot_pwm), exp_mask());
        enable = 1'b0;
        step();
        check("disarm next cycle", int'(mot_pwm), 0);
        for (int i = 0; i < NUM_CH; i++) act_m[i] = 0;
        bus = {16'd3700, 16'd3700, 16'd3700, 16'd3700};
        pulse_load(bus);
        for (int i = 0; i < NUM_CH; i++) pend_m[i] = 50;
        repeat (5) step();
        check("disarmed stays low", int'(mot_pwm), 0);
        enable = 1'b1;
        step();
        check("re-arm mid-period low", int'(mot_pwm), 0);
        for (int p = 0; p < 10; p++) measure($sformatf("rearm p%0d", p));

        // Reset in the middle of a duty-50 period.
        repeat (100) step();
        check("pre-reset high", int'(mot_pwm), 4'hF);
        reset = 1'b1;
        step();
        check("mid reset mot_pwm", int'(mot_pwm), 0);
        check("mid reset period_start", int'(period_start), 0);
        step();
        reset = 1'b0;
        n = 0;
        while (!period_start && n < 3000) begin
            step();
            n++;
        end
        check("first period after reset", n, PLEN);
        for (int i = 0; i < NUM_CH; i++) begin
            act_m[i]  = 0;
            pend_m[i] = 0;
        end
        measure("post reset");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
